// File: rtl/ps2_key_event_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_key_event_if : scan-code input / key-event output bundle       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface ps2_key_event_if;
   logic [7:0]  iDATA;
   logic        iDVAL;
   logic        iACK;
   logic        oEVT_VALID;
   logic [7:0]  oKEY_CODE;
   logic        oEXT;
   logic        oBREAK;
   logic [5:0]  oHELD;
   logic [31:0] oPIXEL_DATA;
   logic        oOVERFLOW;

   modport master (
      output iDATA, iDVAL, iACK,
      input  oEVT_VALID, oKEY_CODE, oEXT, oBREAK, oHELD, oPIXEL_DATA, oOVERFLOW
   );

   modport slave (
      input  iDATA, iDVAL, iACK,
      output oEVT_VALID, oKEY_CODE, oEXT, oBREAK, oHELD, oPIXEL_DATA, oOVERFLOW
   );
endinterface
`default_nettype wire

// File: rtl/ps2_key_event.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_key_event : PS/2 scan-code decoder with event FIFO and held-key |
// | bitmap. Optional typematic filter: PS2_TYPEMATIC_FILTER_EN.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ps2_key_event #(
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic      iCLK,
   input  wire logic      iRST,
   ps2_key_event_if.slave ev_if
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] c_FULL = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] c_ST_IDLE    = 2'd0;
   localparam logic [1:0] c_ST_EXT     = 2'd1;
   localparam logic [1:0] c_ST_BRK     = 2'd2;
   localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             emit_w, ext_w, brk_w, suppress_w, event_w;
   logic [9:0]       evt_word_w;
   logic [5:0]       held_q, held_d;
   logic [9:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [9:0]       head_q, head_d;
   logic             ovf_q, ovf_d;
   logic             pop_w, full_w, push_w;

   always_comb begin
      state_d = state_q;
      emit_w  = 1'b0;
      ext_w   = 1'b0;
      brk_w   = 1'b0;
      if (ev_if.iDVAL) begin
         case (state_q)
            c_ST_IDLE: begin
               case (ev_if.iDATA)
                  8'hE0: state_d = c_ST_EXT;
                  8'hF0: state_d = c_ST_BRK;
                  8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_d = c_ST_IDLE;
                  default: emit_w = 1'b1;
               endcase
            end
            c_ST_EXT: begin
               case (ev_if.iDATA)
                  8'hF0: state_d = c_ST_EXT_BRK;
                  8'hE0: state_d = c_ST_EXT;
                  default: begin
                     emit_w  = 1'b1;
                     ext_w   = 1'b1;
                     state_d = c_ST_IDLE;
                  end
               endcase
            end
            c_ST_BRK: begin
               if (ev_if.iDATA != 8'hF0) begin
                  emit_w  = 1'b1;
                  brk_w   = 1'b1;
                  state_d = c_ST_IDLE;
               end
            end
            default: begin
               if (ev_if.iDATA != 8'hF0) begin
                  emit_w  = 1'b1;
                  ext_w   = 1'b1;
                  brk_w   = 1'b1;
                  state_d = c_ST_IDLE;
               end
            end
         endcase
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic       lm_valid_q, lm_valid_d;
   logic       lm_ext_q, lm_ext_d;
   logic [7:0] lm_code_q, lm_code_d;
   logic       lm_match_w;

   assign lm_match_w = lm_valid_q && (lm_ext_q == ext_w) && (lm_code_q == ev_if.iDATA);
   assign suppress_w = emit_w && !brk_w && lm_match_w;

   always_comb begin
      lm_valid_d = lm_valid_q;
      lm_ext_d   = lm_ext_q;
      lm_code_d  = lm_code_q;
      if (emit_w && !brk_w) begin
         lm_valid_d = 1'b1;
         lm_ext_d   = ext_w;
         lm_code_d  = ev_if.iDATA;
      end else if (emit_w && lm_match_w) begin
         lm_valid_d = 1'b0;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         lm_valid_q <= 1'b0;
         lm_ext_q   <= 1'b0;
         lm_code_q  <= 8'h00;
      end else begin
         lm_valid_q <= lm_valid_d;
         lm_ext_q   <= lm_ext_d;
         lm_code_q  <= lm_code_d;
      end
   end
`else
   assign suppress_w = 1'b0;
`endif

   assign event_w    = emit_w && !suppress_w;
   assign evt_word_w = {ext_w, brk_w, ev_if.iDATA};

   // Held bitmap follows decoded events, independent of FIFO acceptance.
   always_comb begin
      held_d = held_q;
      if (event_w && !ext_w) begin
         case (ev_if.iDATA)
            8'h1D: held_d[0] = !brk_w;
            8'h1C: held_d[1] = !brk_w;
            8'h1B: held_d[2] = !brk_w;
            8'h23: held_d[3] = !brk_w;
            8'h29: held_d[4] = !brk_w;
            8'h5A: held_d[5] = !brk_w;
            default: held_d = held_q;
         endcase
      end
   end

   assign pop_w  = ev_if.iACK && (cnt_q != '0);
   assign full_w = (cnt_q == c_FULL);
   assign push_w = event_w && (!full_w || pop_w);

   always_comb begin
      wr_ptr_d = push_w ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_w  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      ovf_d    = ovf_q || (event_w && full_w && !pop_w);
      case ({push_w, pop_w})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      // New head bypasses the memory when it lands in the slot about to be read.
      if (cnt_d == '0)
         head_d = '0;
      else if (push_w && (wr_ptr_q == rd_ptr_d))
         head_d = evt_word_w;
      else
         head_d = mem_q[rd_ptr_d];
   end

   always_ff @(posedge iCLK) begin
      if (push_w)
         mem_q[wr_ptr_q] <= evt_word_w;
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q  <= c_ST_IDLE;
         held_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         held_q   <= held_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ev_if.oEVT_VALID  = (cnt_q != '0);
   assign ev_if.oKEY_CODE   = head_q[7:0];
   assign ev_if.oBREAK      = head_q[8];
   assign ev_if.oEXT        = head_q[9];
   assign ev_if.oHELD       = held_q;
   assign ev_if.oPIXEL_DATA = {26'b0, held_q};
   assign ev_if.oOVERFLOW   = ovf_q;
endmodule
`default_nettype wire

// File: doc/ps2_key_event.md
PS2_KEY_EVENT -- requirements
Module: ps2_key_event

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries, a power of two from 2 to 16.
REQ-002 The block SHALL have port iCLK, input, 1 bit: system clock, 50 MHz domain; all logic SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port iRST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port iDATA, input, 8 bits: received PS/2 scan-code byte.
REQ-005 The block SHALL have port iDVAL, input, 1 bit: one-cycle strobe qualifying iDATA.
REQ-006 The block SHALL have port iACK, input, 1 bit: consumer pops the head event.
REQ-007 The block SHALL have port oEVT_VALID, output, 1 bit: FIFO non-empty, head event present.
REQ-008 The block SHALL have port oKEY_CODE, output, 8 bits: head event scan code.
REQ-009 The block SHALL have port oEXT, output, 1 bit: head event was E0-prefixed.
REQ-010 The block SHALL have port oBREAK, output, 1 bit: head event is a release (1) or a press (0).
REQ-011 The block SHALL have port oHELD, output, 6 bits: live held-key bitmap {Enter, Space, D, S, A, W}, with bit 0 = W.
REQ-012 The block SHALL have port oPIXEL_DATA, output, 32 bits: {26'b0, oHELD}, the processor input word.
REQ-013 The block SHALL have port oOVERFLOW, output, 1 bit: sticky flag, an event was dropped.

Function
REQ-014 The decoder FSM SHALL have four states: IDLE, EXT, BRK, EXT_BRK; it SHALL advance only on cycles with iDVAL=1.
REQ-015 IDLE transitions SHALL be: E0 -> EXT; F0 -> BRK; 00/AA/EE/FA/FE/FF -> IDLE with no event; any other byte -> emit press {ext=0, code} and stay IDLE.
REQ-016 EXT transitions SHALL be: F0 -> EXT_BRK; E0 -> EXT; any other byte -> emit press {ext=1, code} and go to IDLE.
REQ-017 BRK transitions SHALL be: F0 -> BRK; any other byte -> emit release {ext=0, code} and go to IDLE.
REQ-018 EXT_BRK transitions SHALL be: any byte other than F0 -> emit release {ext=1, code} and go to IDLE; F0 -> EXT_BRK.
REQ-019 An emitted event SHALL be pushed into the FIFO, and oEVT_VALID/oKEY_CODE/oEXT/oBREAK SHALL show it one cycle after the completing iDVAL when the FIFO was empty.
REQ-020 Event words SHALL be 10 bits {ext, break, code}, and the outputs SHALL be registered from the FIFO head.
REQ-021 Pop SHALL occur only when iACK=1 and oEVT_VALID=1; iACK while empty SHALL be ignored.
REQ-022 Push while full SHALL drop the new event and set oOVERFLOW, which SHALL remain set until reset.
REQ-023 Simultaneous push and pop SHALL both be accepted, including when the FIFO is full, and the occupancy SHALL be unchanged.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-025 oHELD SHALL use non-extended codes only: W=1D, A=1C, S=1B, D=23, Space=29, Enter=5A.
REQ-026 A press of one of these keys SHALL set its bit and a release SHALL clear it, one cycle after the completing iDVAL.
REQ-027 oHELD SHALL update even when the event is dropped on overflow.
REQ-028 E0-prefixed codes SHALL never affect oHELD; for example, E0 5A (keypad Enter) SHALL leave bit 5 unchanged.

Reset
REQ-029 While iRST=1 the block SHALL hold: FSM=IDLE, FIFO empty, oEVT_VALID=0, oKEY_CODE=00, oEXT=0, oBREAK=0, oHELD=0, oPIXEL_DATA=0, oOVERFLOW=0, last-make register cleared.
REQ-030 Reset asserted mid-sequence (for example after E0 or F0) SHALL discard the partial sequence, and no event SHALL be emitted on release of reset.
REQ-031 The first iDVAL after reset deassertion SHALL be decoded from IDLE.

Configuration
REQ-032 With macro PS2_TYPEMATIC_FILTER_EN defined, the block SHALL keep a last-make register {valid, ext, code}.
REQ-033 With the filter compiled in, a press matching the valid last-make SHALL be suppressed: no FIFO push and no oHELD change.
REQ-034 With the filter compiled in, any press SHALL load the register, and a release of the same {ext, code} SHALL clear its valid bit.
REQ-035 Without PS2_TYPEMATIC_FILTER_EN, every press SHALL be pushed (typematic repeats included) and the last-make register SHALL be absent.

Verification
REQ-036 Bytes 1D, F0 1D at spaced iDVAL -> press {0,0,1D}, then release {0,1,1D}; oHELD=000001 after the 1st byte and 000000 after F0 1D; oPIXEL_DATA tracks it.
REQ-037 Bytes E0 75, E0 F0 75 -> events {1,0,75} and {1,1,75}; oHELD stays 0; bytes AA and FA alone -> no event.
REQ-038 FIFO_DEPTH=4, iACK=0, six presses 15,16,1E,26,25,2E -> four events held, 25 and 2E dropped, oOVERFLOW=1; four acks -> 15,16,1E,26 in order, then oEVT_VALID=0.
REQ-039 FIFO full with push and iACK in the same cycle -> head popped, new event stored, occupancy stays 4, oOVERFLOW unchanged.
REQ-040 Filter built in: 1C,1C,1C,F0 1C,1C -> exactly press, release, press; filter built out -> four presses and one release. Reset pulse after lone F0, then 1C -> press {0,0,1C}, not a release.
